// File: rtl/pipe_stage_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_chain_pkg
//  Purpose  : Shared bus widths and constants for the writeback pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_chain_pkg;

  localparam int   c_data_bus_w     = 32;
  localparam int   c_reg_addr_bus_w = 5;
  localparam logic c_write_disable  = 1'b0;
  localparam logic c_stall_no       = 1'b0;
  localparam logic c_rst_enable     = 1'b1;

  // A stored write enable is only ever set on a valid, non-guarded entry.
  function automatic logic stage_we(input logic valid, input logic we, input logic guard);
    return valid & we & guard;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : One pipeline stage {v, we, waddr, wdata} with rst/flush/stall/load.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_stage_chain_pkg::*;
#(
  parameter int DATA_W = c_data_bus_w,
  parameter int ADDR_W = c_reg_addr_bus_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              q_valid,
  output logic              q_we,
  output logic [ADDR_W-1:0] q_waddr,
  output logic [DATA_W-1:0] q_wdata
);

  logic              r_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  // Flush clears exactly like reset and wins over stall.
  always_ff @(posedge clk) begin
    if (rst == c_rst_enable || flush) begin
      r_valid <= 1'b0;
      r_we    <= c_write_disable;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (stall == c_stall_no) begin
      r_valid <= d_valid;
      r_we    <= d_we;
      r_waddr <= d_waddr;
      r_wdata <= d_wdata;
    end
  end

  assign q_valid = r_valid;
  assign q_we    = r_we;
  assign q_waddr = r_waddr;
  assign q_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_chain
//  Purpose  : DEPTH-stage writeback pipeline with stall, flush, bubbles,
//             $zero write suppression and occupancy count.
//             Define PIPE_FWD_EN to add the forwarding lookup ports.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int DATA_W         = c_data_bus_w,
  parameter int ADDR_W         = c_reg_addr_bus_w,
  parameter int DEPTH          = 1,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_wdata,
  input  logic [ADDR_W-1:0]          in_waddr,
  input  logic                       in_we,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_wdata,
  output logic [ADDR_W-1:0]          out_waddr,
  output logic                       out_we,
`ifdef PIPE_FWD_EN
  input  logic [ADDR_W-1:0]          fwd_raddr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic              w_v     [DEPTH];
  logic              w_we    [DEPTH];
  logic [ADDR_W-1:0] w_waddr [DEPTH];
  logic [DATA_W-1:0] w_wdata [DEPTH];
  logic              w_guard;
  logic              w_in_we;
  logic [OCC_W-1:0]  w_occ;

  assign w_guard = (ZERO_REG_GUARD != 0) ? (in_waddr != '0) : 1'b1;
  assign w_in_we = stage_we(in_valid, in_we, w_guard);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      pipe_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .stall   (stall),
        .d_valid (in_valid),
        .d_we    (w_in_we),
        .d_waddr (in_waddr),
        .d_wdata (in_wdata),
        .q_valid (w_v[i]),
        .q_we    (w_we[i]),
        .q_waddr (w_waddr[i]),
        .q_wdata (w_wdata[i])
      );
    end else begin : g_body
      pipe_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .stall   (stall),
        .d_valid (w_v[i-1]),
        .d_we    (w_we[i-1]),
        .d_waddr (w_waddr[i-1]),
        .d_wdata (w_wdata[i-1]),
        .q_valid (w_v[i]),
        .q_we    (w_we[i]),
        .q_waddr (w_waddr[i]),
        .q_wdata (w_wdata[i])
      );
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(w_v[i]);
    end
  end

  assign occ       = w_occ;
  assign out_valid = w_v[DEPTH-1];
  assign out_we    = w_we[DEPTH-1];
  assign out_waddr = w_waddr[DEPTH-1];
  assign out_wdata = w_wdata[DEPTH-1];

`ifdef PIPE_FWD_EN
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // Scan oldest to youngest so the youngest match is the last to win.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (w_v[i] && w_we[i] && (w_waddr[i] == fwd_raddr) && (fwd_raddr != '0)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_wdata[i];
      end
    end
  end

  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_chain
//  Purpose  : Directed self-checking bench for pipe_stage_chain, DEPTH=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;

  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic              in_valid, in_we;
  logic [DATA_W-1:0] in_wdata;
  logic [ADDR_W-1:0] in_waddr;
  logic              out_valid, out_we;
  logic [DATA_W-1:0] out_wdata;
  logic [ADDR_W-1:0] out_waddr;
  logic [1:0]        occ;
`ifdef PIPE_FWD_EN
  logic [ADDR_W-1:0] fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  int n_eval = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG_GUARD(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_wdata  (in_wdata),
    .in_waddr  (in_waddr),
    .in_we     (in_we),
    .out_valid (out_valid),
    .out_wdata (out_wdata),
    .out_waddr (out_waddr),
    .out_we    (out_we),
`ifdef PIPE_FWD_EN
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
`endif
    .occ       (occ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] a, input logic we);
    in_valid = v; in_wdata = d; in_waddr = a; in_we = we;
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [4:0] a, input logic we, input logic [1:0] o);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_wdata"}, out_wdata, d);
    check({tag, "_waddr"}, 32'(out_waddr), 32'(a));
    check({tag, "_we"},    32'(out_we), 32'(we));
    check({tag, "_occ"},   32'(occ), 32'(o));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0);
`ifdef PIPE_FWD_EN
    fwd_raddr = '0;
`endif
    tick(); tick();
    check_out("reset", 1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    rst = 1'b0;

    // Fill three entries; first reaches the output after three edges.
    drive(1'b1, 32'hA1, 5'd1, 1'b1); tick();
    check_out("fill1", 1'b0, 32'h0, 5'd0, 1'b0, 2'd1);
    drive(1'b1, 32'hA2, 5'd2, 1'b1); tick();
    check_out("fill2", 1'b0, 32'h0, 5'd0, 1'b0, 2'd2);
    drive(1'b1, 32'hA3, 5'd3, 1'b1); tick();
    check_out("fill3", 1'b1, 32'hA1, 5'd1, 1'b1, 2'd3);
    drive(1'b1, 32'hB1, 5'd4, 1'b1); tick();
    check_out("fill4", 1'b1, 32'hA2, 5'd2, 1'b1, 2'd3);

    // Two stall cycles freeze everything and drop the presented input.
    stall = 1'b1;
    drive(1'b1, 32'hEE, 5'd9, 1'b1); tick();
    check_out("stall1", 1'b1, 32'hA2, 5'd2, 1'b1, 2'd3);
    tick();
    check_out("stall2", 1'b1, 32'hA2, 5'd2, 1'b1, 2'd3);
    stall = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick();
    check_out("drain1", 1'b1, 32'hA3, 5'd3, 1'b1, 2'd2);
    tick();
    check_out("drain2", 1'b1, 32'hB1, 5'd4, 1'b1, 2'd1);
    tick();
    check_out("drain3", 1'b0, 32'h0, 5'd0, 1'b0, 2'd0);

    // Flush wins over stall.
    drive(1'b1, 32'hC1, 5'd7, 1'b1); tick();
    drive(1'b1, 32'hC2, 5'd8, 1'b1); tick();
    drive(1'b1, 32'hC3, 5'd9, 1'b1); tick();
    check_out("pre_flush", 1'b1, 32'hC1, 5'd7, 1'b1, 2'd3);
    flush = 1'b1; stall = 1'b1; tick();
    check_out("flush", 1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    flush = 1'b0; stall = 1'b0;

    // Reset wins over stall.
    drive(1'b1, 32'hD1, 5'd10, 1'b1); tick();
    drive(1'b1, 32'hD2, 5'd11, 1'b1); tick();
    drive(1'b1, 32'hD3, 5'd12, 1'b1); tick();
    check_out("pre_rst", 1'b1, 32'hD1, 5'd10, 1'b1, 2'd3);
    rst = 1'b1; stall = 1'b1; tick();
    check_out("rst_stall", 1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    rst = 1'b0; stall = 1'b0;

    // Bubbles carry addr/data but never valid or write enable.
    drive(1'b0, 32'h55, 5'd6, 1'b1); tick(); tick(); tick();
    check_out("bubble", 1'b0, 32'h55, 5'd6, 1'b0, 2'd0);

    // A write to $zero stays valid but has its enable stripped.
    drive(1'b1, 32'h77, 5'd0, 1'b1); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick(); tick();
    check_out("zero_reg", 1'b1, 32'h77, 5'd0, 1'b0, 2'd1);

    // A valid entry with we=0 passes through without writing.
    drive(1'b1, 32'h99, 5'd3, 1'b0); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0); tick(); tick();
    check_out("no_we", 1'b1, 32'h99, 5'd3, 1'b0, 2'd1);

`ifdef PIPE_FWD_EN
    drive(1'b1, 32'h11, 5'd5, 1'b1); tick();
    drive(1'b1, 32'h22, 5'd5, 1'b1); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0);
    fwd_raddr = 5'd5; #1;
    check("fwd5_hit",  32'(fwd_hit), 32'd1);
    check("fwd5_data", fwd_data, 32'h22);
    fwd_raddr = 5'd0; #1;
    check("fwd0_hit",  32'(fwd_hit), 32'd0);
    check("fwd0_data", fwd_data, 32'h0);
    fwd_raddr = 5'd7; #1;
    check("fwd7_hit",  32'(fwd_hit), 32'd0);
    check("fwd7_data", fwd_data, 32'h0);
    tick();
    fwd_raddr = 5'd5; #1;
    check("fwd_old_data", fwd_data, 32'h22);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
